// File: rtl/maxi_ll_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : maxi_ll_mem_responder
// Desc   : Packed-valid 64-bit AXI3-style slave serving reads/writes from a
//          word-addressed internal memory; stands in for DRAM on IP_MAXI0.
// Rev    : 1.0  initial release
// ============================================================================
module maxi_ll_mem_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          WORDS_LOG2 = 10,
    parameter string       INIT_FILE  = ""
) (
    input  logic        IP_CLK,
    input  logic        IP_ARESET_N,
    input  logic [32:0] IP_MAXI0_ARADDR,
    output logic        IP_MAXI0_ARADDR_ready,
    input  logic [3:0]  IP_MAXI0_ARLEN,
    input  logic [1:0]  IP_MAXI0_ARSIZE,
    input  logic [1:0]  IP_MAXI0_ARBURST,
    output logic [64:0] IP_MAXI0_RDATA,
    input  logic        IP_MAXI0_RDATA_ready,
    output logic [1:0]  IP_MAXI0_RRESP,
    output logic        IP_MAXI0_RLAST,
    input  logic [32:0] IP_MAXI0_AWADDR,
    output logic        IP_MAXI0_AWADDR_ready,
    input  logic [3:0]  IP_MAXI0_AWLEN,
    input  logic [1:0]  IP_MAXI0_AWSIZE,
    input  logic [1:0]  IP_MAXI0_AWBURST,
    input  logic [64:0] IP_MAXI0_WDATA,
    output logic        IP_MAXI0_WDATA_ready,
    input  logic [7:0]  IP_MAXI0_WSTRB,
    input  logic        IP_MAXI0_WLAST,
    output logic [2:0]  IP_MAXI0_BRESP,
    input  logic        IP_MAXI0_BRESP_ready
);

    typedef enum logic       {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [63:0] mem [0:(1 << WORDS_LOG2) - 1];

    // Offset is taken 33 bits wide so addresses below BASE_ADDR land far out of range.
    function automatic logic [32:0] word_of(input logic [31:0] addr);
        logic [32:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE_ADDR};
        return diff >> 3;
    endfunction

    logic        rst_done_q;
    r_state_t    r_state_q, r_state_d;
    logic [32:0] r_word_q, r_word_d;
    logic [3:0]  r_len_q, r_len_d, r_beat_q, r_beat_d;
    logic        r_legal_q, r_legal_d;
    logic [63:0] r_data_q, r_data_d;
    logic [1:0]  r_resp_q, r_resp_d;
    logic        r_last_q, r_last_d;
    logic        r_load, r_ok;

    w_state_t    w_state_q, w_state_d;
    logic [32:0] w_word_q, w_word_d;
    logic [3:0]  w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic        w_legal_q, w_legal_d;
    logic        w_err_q, w_err_d;
    logic        w_mem_we, w_is_last, w_ok;

    assign IP_MAXI0_ARADDR_ready = rst_done_q && (r_state_q == R_IDLE);
    assign IP_MAXI0_RDATA        = {r_state_q == R_BURST, r_data_q};
    assign IP_MAXI0_RRESP        = r_resp_q;
    assign IP_MAXI0_RLAST        = r_last_q;
    assign IP_MAXI0_AWADDR_ready = rst_done_q && (w_state_q == W_IDLE);
    assign IP_MAXI0_WDATA_ready  = (w_state_q == W_DATA);
    assign IP_MAXI0_BRESP        = {w_state_q == W_RESP, w_err_q, 1'b0};

    always_comb begin
        r_state_d = r_state_q;
        r_word_d  = r_word_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_legal_d = r_legal_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        r_last_d  = r_last_q;
        r_load    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (IP_MAXI0_ARADDR[32] && IP_MAXI0_ARADDR_ready) begin
                    r_state_d = R_BURST;
                    r_word_d  = word_of(IP_MAXI0_ARADDR[31:0]);
                    r_len_d   = IP_MAXI0_ARLEN;
                    r_beat_d  = 4'd0;
                    r_legal_d = (IP_MAXI0_ARSIZE == 2'b11) && (IP_MAXI0_ARBURST == 2'b01);
                    r_load    = 1'b1;
                end
            end
            R_BURST: begin
                if (IP_MAXI0_RDATA_ready) begin
                    if (r_beat_q == r_len_q) begin
                        r_state_d = R_IDLE;
                        r_data_d  = 64'h0;
                        r_resp_d  = 2'b00;
                        r_last_d  = 1'b0;
                    end else begin
                        r_beat_d = r_beat_q + 4'd1;
                        r_word_d = r_word_q + 33'd1;
                        r_load   = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // Beat data is sampled here, so a write landing on the same edge is not seen.
        r_ok = (r_word_d[32:WORDS_LOG2] == '0) && r_legal_d;
        if (r_load) begin
            r_data_d = r_ok ? mem[r_word_d[WORDS_LOG2-1:0]] : 64'h0;
            r_resp_d = r_ok ? 2'b00 : 2'b10;
            r_last_d = (r_beat_d == r_len_d);
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_word_d  = w_word_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_legal_d = w_legal_q;
        w_err_d   = w_err_q;
        w_mem_we  = 1'b0;
        w_is_last = (w_beat_q == w_len_q);
        w_ok      = (w_word_q[32:WORDS_LOG2] == '0) && w_legal_q;
        case (w_state_q)
            W_IDLE: begin
                if (IP_MAXI0_AWADDR[32] && IP_MAXI0_AWADDR_ready) begin
                    w_state_d = W_DATA;
                    w_word_d  = word_of(IP_MAXI0_AWADDR[31:0]);
                    w_len_d   = IP_MAXI0_AWLEN;
                    w_beat_d  = 4'd0;
                    w_legal_d = (IP_MAXI0_AWSIZE == 2'b11) && (IP_MAXI0_AWBURST == 2'b01);
                end
            end
            W_DATA: begin
                if (IP_MAXI0_WDATA[64]) begin
                    w_mem_we = w_ok;
                    if (!w_ok || (IP_MAXI0_WLAST != w_is_last)) begin
                        w_err_d = 1'b1;
                    end
                    if (w_is_last) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_beat_d = w_beat_q + 4'd1;
                        w_word_d = w_word_q + 33'd1;
                    end
                end
            end
            W_RESP: begin
                if (IP_MAXI0_BRESP_ready) begin
                    w_state_d = W_IDLE;
                    w_err_d   = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge IP_CLK or negedge IP_ARESET_N) begin
        if (!IP_ARESET_N) begin
            rst_done_q <= 1'b0;
            r_state_q  <= R_IDLE;
            r_word_q   <= '0;
            r_len_q    <= '0;
            r_beat_q   <= '0;
            r_legal_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
            r_last_q   <= 1'b0;
            w_state_q  <= W_IDLE;
            w_word_q   <= '0;
            w_len_q    <= '0;
            w_beat_q   <= '0;
            w_legal_q  <= 1'b0;
            w_err_q    <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            r_state_q  <= r_state_d;
            r_word_q   <= r_word_d;
            r_len_q    <= r_len_d;
            r_beat_q   <= r_beat_d;
            r_legal_q  <= r_legal_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            r_last_q   <= r_last_d;
            w_state_q  <= w_state_d;
            w_word_q   <= w_word_d;
            w_len_q    <= w_len_d;
            w_beat_q   <= w_beat_d;
            w_legal_q  <= w_legal_d;
            w_err_q    <= w_err_d;
        end
    end

    always_ff @(posedge IP_CLK) begin
        if (w_mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (IP_MAXI0_WSTRB[i]) begin
                    mem[w_word_q[WORDS_LOG2-1:0]][8*i +: 8] <= IP_MAXI0_WDATA[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maxi_ll_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_maxi_ll_mem_responder
// Desc   : Directed self-checking bench for maxi_ll_mem_responder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_maxi_ll_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [32:0] araddr;
    logic        ar_ready;
    logic [3:0]  arlen;
    logic [1:0]  arsize, arburst;
    logic [64:0] rdata;
    logic        rready;
    logic [1:0]  rresp;
    logic        rlast;
    logic [32:0] awaddr;
    logic        aw_ready;
    logic [3:0]  awlen;
    logic [1:0]  awsize, awburst;
    logic [64:0] wdata;
    logic        wready;
    logic [7:0]  wstrb;
    logic        wlast;
    logic [2:0]  bresp;
    logic        bready;

    int checks = 0;
    int errors = 0;

    logic [63:0] wd [16];
    logic [63:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [2:0]  b;
    int          nb, lat, unst;

    maxi_ll_mem_responder dut (
        .IP_CLK               (clk),
        .IP_ARESET_N          (rst_n),
        .IP_MAXI0_ARADDR      (araddr),
        .IP_MAXI0_ARADDR_ready(ar_ready),
        .IP_MAXI0_ARLEN       (arlen),
        .IP_MAXI0_ARSIZE      (arsize),
        .IP_MAXI0_ARBURST     (arburst),
        .IP_MAXI0_RDATA       (rdata),
        .IP_MAXI0_RDATA_ready (rready),
        .IP_MAXI0_RRESP       (rresp),
        .IP_MAXI0_RLAST       (rlast),
        .IP_MAXI0_AWADDR      (awaddr),
        .IP_MAXI0_AWADDR_ready(aw_ready),
        .IP_MAXI0_AWLEN       (awlen),
        .IP_MAXI0_AWSIZE      (awsize),
        .IP_MAXI0_AWBURST     (awburst),
        .IP_MAXI0_WDATA       (wdata),
        .IP_MAXI0_WDATA_ready (wready),
        .IP_MAXI0_WSTRB       (wstrb),
        .IP_MAXI0_WLAST       (wlast),
        .IP_MAXI0_BRESP       (bresp),
        .IP_MAXI0_BRESP_ready (bready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len,
                             input logic [7:0] strb, input int last_beat,
                             output logic [2:0] resp);
        int n;
        awaddr = {1'b1, addr}; awlen = len; awsize = 2'b11; awburst = 2'b01;
        n = 0;
        while (!aw_ready && n < 20) begin tick(); n++; end
        check("aw_wait", (n < 20) ? 64'd1 : 64'd0, 64'd1);
        tick();
        awaddr = '0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = {1'b1, wd[i]}; wstrb = strb; wlast = (i == last_beat);
            n = 0;
            while (!wready && n < 20) begin tick(); n++; end
            tick();
        end
        wdata = '0; wlast = 1'b0; wstrb = '0;
        n = 0;
        while (!bresp[2] && n < 20) begin tick(); n++; end
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] size, input logic [15:0] rdy_pat,
                            output int nbeats, output int lat_ok, output int unstable);
        int n, cyc;
        logic [67:0] prev;
        logic        have_prev;
        araddr = {1'b1, addr}; arlen = len; arsize = size; arburst = 2'b01;
        n = 0;
        while (!ar_ready && n < 20) begin tick(); n++; end
        tick();
        araddr = '0;
        lat_ok = int'(rdata[64]);
        nbeats = 0; cyc = 0; unstable = 0; have_prev = 1'b0; prev = '0;
        while (nbeats <= int'(len) && cyc < 100) begin
            rready = rdy_pat[cyc % 16];
            if (have_prev && ({rdata, rresp, rlast} !== prev)) unstable++;
            have_prev = 1'b0;
            if (rdata[64] && rready) begin
                rd_data[nbeats] = rdata[63:0];
                rd_resp[nbeats] = rresp;
                rd_last[nbeats] = rlast;
                nbeats++;
            end else if (rdata[64]) begin
                prev = {rdata, rresp, rlast};
                have_prev = 1'b1;
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; rready = 1'b0; bready = 1'b0;
        araddr = {1'b1, 32'h3000_0000}; arlen = '0; arsize = 2'b11; arburst = 2'b01;
        awaddr = '0; awlen = '0; awsize = 2'b11; awburst = 2'b01;
        wdata = '0; wstrb = '0; wlast = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();

        check("rst_ar_ready", {63'b0, ar_ready}, 64'd0);
        check("rst_rvalid",   {63'b0, rdata[64]}, 64'd0);
        check("rst_aw_ready", {63'b0, aw_ready}, 64'd0);
        check("rst_wready",   {63'b0, wready}, 64'd0);
        check("rst_bresp",    {61'b0, bresp}, 64'd0);
        rst_n = 1'b1;
        check("rel_ar_ready_pre", {63'b0, ar_ready}, 64'd0);
        tick();
        check("rel_ar_ready_post", {63'b0, ar_ready}, 64'd1);
        araddr = '0;
        tick();

        // Basic 4-beat write then read-back.
        wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
        wd[2] = 64'h3333_3333_3333_3333; wd[3] = 64'h4444_4444_4444_4444;
        axi_write(32'h3000_0010, 4'd3, 8'hFF, 3, b);
        check("wr_bresp", {61'b0, b}, 64'h4);
        axi_read(32'h3000_0010, 4'd3, 2'b11, 16'hFFFF, nb, lat, unst);
        check("rd_nbeats", 64'(nb), 64'd4);
        check("rd_latency", 64'(lat), 64'd1);
        check("rd_d0", rd_data[0], 64'h1111_1111_1111_1111);
        check("rd_d1", rd_data[1], 64'h2222_2222_2222_2222);
        check("rd_d2", rd_data[2], 64'h3333_3333_3333_3333);
        check("rd_d3", rd_data[3], 64'h4444_4444_4444_4444);
        check("rd_resp", {56'b0, rd_resp[0], rd_resp[1], rd_resp[2], rd_resp[3]}, 64'h0);
        check("rd_last", {60'b0, rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 64'b0001);
        check("rd_ar_ready_back", {63'b0, ar_ready}, 64'd1);

        // Partial byte strobes.
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        axi_write(32'h3000_0100, 4'd0, 8'hFF, 0, b);
        wd[0] = 64'hAAAA_AAAA_BBBB_BBBB;
        axi_write(32'h3000_0100, 4'd0, 8'h0F, 0, b);
        check("strb_bresp", {61'b0, b}, 64'h4);
        axi_read(32'h3000_0100, 4'd0, 2'b11, 16'hFFFF, nb, lat, unst);
        check("strb_data", rd_data[0], 64'hFFFF_FFFF_BBBB_BBBB);

        // Backpressure on R: beats must hold and none be lost or repeated.
        axi_read(32'h3000_0010, 4'd3, 2'b11, 16'b1001_1001_1001_1001, nb, lat, unst);
        check("bp_nbeats", 64'(nb), 64'd4);
        check("bp_unstable", 64'(unst), 64'd0);
        check("bp_d0", rd_data[0], 64'h1111_1111_1111_1111);
        check("bp_d1", rd_data[1], 64'h2222_2222_2222_2222);
        check("bp_d2", rd_data[2], 64'h3333_3333_3333_3333);
        check("bp_d3", rd_data[3], 64'h4444_4444_4444_4444);

        // Memory end: write crossing end errors, read crossing end returns OKAY then SLVERR.
        wd[0] = 64'h5555_5555_5555_5555; wd[1] = 64'h6666_6666_6666_6666;
        axi_write(32'h3000_1FF8, 4'd1, 8'hFF, 1, b);
        check("end_wr_bresp", {61'b0, b}, 64'h6);
        axi_read(32'h3000_1FF8, 4'd1, 2'b11, 16'hFFFF, nb, lat, unst);
        check("end_rd_d0", rd_data[0], 64'h5555_5555_5555_5555);
        check("end_rd_r0", {62'b0, rd_resp[0]}, 64'h0);
        check("end_rd_d1", rd_data[1], 64'h0);
        check("end_rd_r1", {62'b0, rd_resp[1]}, 64'h2);
        check("end_rd_last1", {63'b0, rd_last[1]}, 64'd1);

        // Early WLAST, then a clean write must report OKAY again.
        wd[0] = 64'h7; wd[1] = 64'h8; wd[2] = 64'h9; wd[3] = 64'hA;
        axi_write(32'h3000_0040, 4'd3, 8'hFF, 1, b);
        check("early_wlast_bresp", {61'b0, b}, 64'h6);
        wd[0] = 64'h0123_4567_89AB_CDEF;
        axi_write(32'h3000_0048, 4'd0, 8'hFF, 0, b);
        check("after_err_bresp", {61'b0, b}, 64'h4);

        // Illegal ARSIZE gives SLVERR with zero data.
        axi_read(32'h3000_0010, 4'd0, 2'b10, 16'hFFFF, nb, lat, unst);
        check("badsize_resp", {62'b0, rd_resp[0]}, 64'h2);
        check("badsize_data", rd_data[0], 64'h0);

        // Asynchronous reset in the middle of a read burst.
        araddr = {1'b1, 32'h3000_0010}; arlen = 4'd3; arsize = 2'b11; arburst = 2'b01;
        tick();
        araddr = '0;
        rready = 1'b1;
        tick();
        tick();
        check("mid_valid", {63'b0, rdata[64]}, 64'd1);
        check("mid_beat2", rdata[63:0], 64'h3333_3333_3333_3333);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", {63'b0, rdata[64]}, 64'd0);
        check("mid_rst_ar_ready", {63'b0, ar_ready}, 64'd0);
        rready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rel_ar_ready", {63'b0, ar_ready}, 64'd1);
        axi_read(32'h3000_0010, 4'd3, 2'b11, 16'hFFFF, nb, lat, unst);
        check("post_rst_nbeats", 64'(nb), 64'd4);
        check("post_rst_d0", rd_data[0], 64'h1111_1111_1111_1111);
        check("post_rst_d3", rd_data[3], 64'h4444_4444_4444_4444);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
